// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
//   Shared constants and helpers for the programmable serial pattern detector.
//   - DEF_W / DEF_PATTERN / DEF_OVERLAP : reset-time configuration used when
//     the detector is built at its default width (1101 detector, overlap on).
//   - clog2 : ceiling log2, used to size the history fill counter.
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int          DEF_W       = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b1101;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Ceiling log2 with a floor of 1 so that a counter sized from it always
    // has at least one bit. A counter of clog2(W) bits holds 0..W-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for match statistics.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-high reset, clears count
//     inc    in   increment request (ignored once saturated)
//     clr    in   synchronous clear, wins over inc
//     count  out  CW-bit current count
//     sat    out  high while count is all ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          sat
);

    always_comb begin
        sat = &count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
//   Programmable serial bit-pattern detector with Mealy match output and a
//   saturating match counter.
//   Parameters:
//     W               pattern length (>= 2)
//     CW              match counter width
//     DEFAULT_PATTERN pattern after reset, first-received bit in the MSB
//     DEFAULT_MASK    compare mask after reset (1 = compare, 0 = don't care)
//     DEFAULT_OVERLAP overlap mode after reset
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-high reset
//     x_valid      in   x carries a stream bit this cycle
//     x            in   serial stream bit
//     cfg_load     in   latch cfg_* (clears history and counter, drops bit)
//     cfg_pattern  in   new pattern
//     cfg_mask     in   new mask
//     cfg_overlap  in   new overlap mode
//     count_clr    in   synchronous clear of match_count
//     y            out  combinational match, valid with the final bit
//     match_count  out  saturating number of matches
//     count_sat    out  high while match_count is all ones
// -----------------------------------------------------------------------------
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int           W               = DEF_W,
    parameter int           CW              = 8,
    parameter logic [W-1:0] DEFAULT_PATTERN = W'(DEF_PATTERN),
    parameter logic [W-1:0] DEFAULT_MASK    = {W{1'b1}},
    parameter logic         DEFAULT_OVERLAP = DEF_OVERLAP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    input  logic          x,
    input  logic          cfg_load,
    input  logic [W-1:0]  cfg_pattern,
    input  logic [W-1:0]  cfg_mask,
    input  logic          cfg_overlap,
    input  logic          count_clr,
    output logic          y,
    output logic [CW-1:0] match_count,
    output logic          count_sat
);

    localparam int           FW       = clog2(W);
    localparam logic [FW-1:0] FILL_MAX = FW'(W - 1);

    // Live configuration
    logic [W-1:0]  pat;
    logic [W-1:0]  msk;
    logic          ovl;

    // Stream history: last W-1 accepted bits, newest at the LSB, and how many
    // of them are meaningful (saturates at W-1).
    logic [W-2:0]  hist;
    logic [FW-1:0] fill;

    logic [W-1:0]  cand;
    logic          full;
    logic          hit;
    logic          accept;

    // Candidate window: oldest history bit lines up with pat[W-1], the bit
    // arriving now lines up with pat[0].
    always_comb begin
        cand   = {hist, x};
        full   = (fill == FILL_MAX);
        hit    = (((cand ^ pat) & msk) == '0);
        accept = x_valid && !cfg_load;
        // reset is folded in so y drops the moment reset rises, without
        // waiting for the registers to be observed as cleared.
        y      = accept && !reset && full && hit;
    end

    // Configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat <= DEFAULT_PATTERN;
            msk <= DEFAULT_MASK;
            ovl <= DEFAULT_OVERLAP;
        end else if (cfg_load) begin
            pat <= cfg_pattern;
            msk <= cfg_mask;
            ovl <= cfg_overlap;
        end
    end

    // History and fill tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (cfg_load) begin
            // New configuration starts from an empty window; the bit that
            // arrived alongside the load is dropped.
            hist <= '0;
            fill <= '0;
        end else if (x_valid) begin
            hist <= cand[W-2:0];
            if (y && !ovl) begin
                // Non-overlapping: the matched bits may not be reused, so the
                // window must refill completely before the next compare.
                fill <= '0;
            end else if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Match statistics; a configuration load also restarts the count.
    sat_counter #(
        .CW (CW)
    ) u_sat_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (y),
        .clr   (count_clr || cfg_load),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule : seq_detector_prog

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

    logic       clk;
    logic       reset;
    logic       x_valid;
    logic       x;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic [3:0] cfg_mask;
    logic       cfg_overlap;
    logic       count_clr;

    logic       y;
    logic [7:0] match_count;
    logic       count_sat;

    logic       y2;
    logic [1:0] cnt2;
    logic       sat2;

    int checks;
    int failures;

    seq_detector_prog #(.W(4), .CW(8)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .x_valid     (x_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .y           (y),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    seq_detector_prog #(.W(4), .CW(2)) u_dut_cw2 (
        .clk         (clk),
        .reset       (reset),
        .x_valid     (x_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .y           (y2),
        .match_count (cnt2),
        .count_sat   (sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one valid bit, check y before the edge that accepts it.
    task automatic send(input logic b, input logic ey, input string tag);
        @(negedge clk);
        x_valid   = 1'b1;
        x         = b;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
        #1 check_eq(tag, {31'd0, y}, {31'd0, ey});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            x_valid   = 1'b0;
            cfg_load  = 1'b0;
            count_clr = 1'b0;
            #1 check_eq("idle_y", {31'd0, y}, 32'd0);
        end
    endtask

    // Send n bits MSB first; ys holds the expected y for each bit.
    task automatic stream(input logic [7:0] bits, input logic [7:0] ys, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], ys[i], tag);
        end
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m, input logic o);
        @(negedge clk);
        x_valid     = 1'b0;
        count_clr   = 1'b0;
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = o;
        @(negedge clk);
        cfg_load = 1'b0;
        #1 check_eq("load_cnt", {24'd0, match_count}, 32'd0);
    endtask

    task automatic check_count(input string tag, input logic [7:0] exp);
        idle(1);
        check_eq(tag, {24'd0, match_count}, {24'd0, exp});
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        x_valid     = 1'b0;
        x           = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 4'b0000;
        cfg_mask    = 4'b0000;
        cfg_overlap = 1'b0;
        count_clr   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_y",   {31'd0, y},           32'd0);
        check_eq("rst_cnt", {24'd0, match_count}, 32'd0);
        check_eq("rst_sat", {31'd0, count_sat},   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: defaults, overlapping 1101 in 1101101
        stream(8'b0110_1101, 8'b0000_1001, 7, "t1_ovl_y");
        check_count("t1_cnt", 8'd2);

        // 2: non-overlapping
        load(4'b1101, 4'b1111, 1'b0);
        stream(8'b0110_1101, 8'b0000_1000, 7, "t2_novl_y");
        check_count("t2_cnt", 8'd1);

        // 3a: idle gaps between bits
        load(4'b1101, 4'b1111, 1'b1);
        send(1'b1, 1'b0, "t3_gap_y"); idle(3);
        send(1'b1, 1'b0, "t3_gap_y"); idle(3);
        send(1'b0, 1'b0, "t3_gap_y"); idle(3);
        send(1'b1, 1'b1, "t3_gap_last");
        check_count("t3_gap_cnt", 8'd1);

        // 3b: masked compare, bit 2 don't care
        load(4'b1001, 4'b1011, 1'b0);
        stream(8'b0000_1101, 8'b0000_0001, 4, "t3_mask_hit");
        check_count("t3_mask_cnt", 8'd1);
        load(4'b1001, 4'b1011, 1'b0);
        stream(8'b0000_0101, 8'b0000_0000, 4, "t3_mask_miss");
        check_count("t3_miss_cnt", 8'd0);

        // 4: saturation with all-don't-care mask
        load(4'b0000, 4'b0000, 1'b1);
        stream(8'b0000_0111, 8'b0000_0000, 3, "t4_fill_y");
        stream(8'b0001_0110, 8'b0001_1111, 5, "t4_any_y");
        idle(1);
        check_eq("t4_cnt2", {30'd0, cnt2}, 32'd3);
        check_eq("t4_sat2", {31'd0, sat2}, 32'd1);
        check_eq("t4_cnt8", {24'd0, match_count}, 32'd5);
        check_eq("t4_sat8", {31'd0, count_sat}, 32'd0);
        // clear together with a match
        @(negedge clk);
        x_valid   = 1'b1;
        x         = 1'b0;
        count_clr = 1'b1;
        #1 check_eq("t4_clr_y", {31'd0, y2}, 32'd1);
        idle(1);
        check_eq("t4_clr_cnt2", {30'd0, cnt2}, 32'd0);
        check_eq("t4_clr_sat2", {31'd0, sat2}, 32'd0);
        check_eq("t4_clr_cnt8", {24'd0, match_count}, 32'd0);

        // 5: cfg_load wins over a bit that would complete 1101
        load(4'b1101, 4'b1111, 1'b1);
        stream(8'b0000_0110, 8'b0000_0000, 3, "t5_pre_y");
        @(negedge clk);
        x_valid     = 1'b1;
        x           = 1'b1;
        cfg_load    = 1'b1;
        cfg_pattern = 4'b1101;
        cfg_mask    = 4'b1111;
        cfg_overlap = 1'b1;
        #1 check_eq("t5_load_y", {31'd0, y}, 32'd0);
        send(1'b1, 1'b0, "t5_next_y");
        check_eq("t5_load_cnt", {24'd0, match_count}, 32'd0);
        stream(8'b0000_0101, 8'b0000_0001, 3, "t5_fresh_y");
        check_count("t5_cnt", 8'd1);

        // 6: async reset mid-stream restores defaults
        load(4'b0000, 4'b0000, 1'b0);
        stream(8'b0000_0110, 8'b0000_0000, 3, "t6_pre_y");
        @(negedge clk);
        x_valid = 1'b1;
        x       = 1'b1;
        #1 check_eq("t6_before_rst_y", {31'd0, y}, 32'd1);
        #1 reset = 1'b1;
        #1 check_eq("t6_rst_y", {31'd0, y}, 32'd0);
        check_eq("t6_rst_cnt", {24'd0, match_count}, 32'd0);
        @(negedge clk);
        x_valid = 1'b0;
        reset   = 1'b0;
        stream(8'b0110_1101, 8'b0000_1001, 7, "t6_post_y");
        check_count("t6_cnt", 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_detector_prog
